seq_muldiv: RTL and testbench
=============================

// Module: seq_muldiv
// PURPOSE
//  Iterative multi-cycle multiply/divide unit with architectural HI/LO registers.
//  Parametrised successor of the combinational multiplier:
//   - generic WIDTH;
//   - signed and unsigned multiply and divide;
//   - start/busy/done handshake;
//   - software-writable HI/LO.
//  Sits beside the ALU in the EX stage; the hazard unit stalls on busy.
// PARAMETERS
//  WIDTH  32  operand width; HI and LO are each WIDTH bits (WIDTH >= 4)
// PORTS
//  clk     in   1      single clock, rising edge
//  reset   in   1      synchronous, active-high
//  start   in   1      launch op; sampled only when busy=0
//  op      in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//  a       in   WIDTH  multiplicand / dividend; latched at start
//  b       in   WIDTH  multiplier / divisor; latched at start
//  hi_we   in   1      write HI from wdata (mthi)
//  lo_we   in   1      write LO from wdata (mtlo)
//  wdata   in   WIDTH  HI/LO write data
//  busy    out  1      operation in flight
//  done    out  1      one-cycle pulse: HI/LO just updated by an op
//  hi      out  WIDTH  HI register (product upper half / remainder)
//  lo      out  WIDTH  LO register (product lower half / quotient)
// BEHAVIOUR
//  - Reset (any time, including mid-op):
//    - next edge: state=IDLE, busy=0, done=0, hi=0, lo=0;
//    - the in-flight op is discarded; no done is produced.
//  - FSM states: IDLE -> RUN (WIDTH cycles) -> FIX (1 cycle) -> IDLE.
//  - IDLE:
//    - start=1 at edge E0 latches a, b, op, and operand magnitudes (signed ops);
//    - counter=0; go to RUN.
//  - RUN: one radix-2 step per cycle.
//    - Mult: shift-add on magnitudes, 2*WIDTH-bit accumulator.
//    - Div: restoring shift-subtract, partial remainder WIDTH+1 bits.
//    - Leave after counter reaches WIDTH-1.
//  - FIX:
//    - apply sign correction;
//    - write hi/lo at the edge ending FIX (E0+WIDTH+1);
//    - done=1 for exactly the following cycle; return to IDLE.
//  - busy=1 from after E0 through the end of FIX: WIDTH+1 cycles.
//  - busy is a registered output; done rises in the same cycle busy falls.
//  - Arithmetic rules:
//    - Signed mult: product negated iff a[W-1]^b[W-1]; full 2W-bit two's complement.
//    - Signed div truncates toward zero:
//      quotient negative iff signs differ; remainder takes the sign of a.
//    - b=0, any div: lo={WIDTH{1'b1}}, hi=a. Detected at start; still takes the
//      full WIDTH+1 cycles so latency is data-independent.
//    - DIV of MIN by -1: lo=MIN, hi=0; falls out of the magnitude algorithm, no trap.
//  - start while busy=1: ignored; no queuing.
//  - hi_we/lo_we while busy=1: ignored; the hazard unit must stall mthi/mtlo.
//  - hi_we/lo_we while idle: register written at that edge.
//  - Same-edge start+hi_we/lo_we when idle: the write takes effect now;
//    the op's result overwrites it at E0+WIDTH+1.
//  - hi/lo hold their value during RUN and FIX: the old result stays readable
//    until done.
// STRUCTURE
//  - muldiv_pkg holds:
//    - op encodings: OP_MULTU, OP_MULT, OP_DIVU, OP_DIV;
//    - FSM state encodings: S_IDLE, S_RUN, S_FIX;
//    - helper function abs_val(width-generic via parameter).
//  - One natural sub-module: muldiv_signfix (combinational).
//    - Inputs: raw magnitude result, op, and latched operand signs.
//    - Outputs: final hi/lo, including the b=0 override.
//  - FSM, counter and accumulator live in seq_muldiv.
// TESTING
//  1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001;
//     busy high 33 cycles; done pulses once.
//  2. MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB(-21).
//  3. DIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF;
//     DIVU a=7 b=2 -> lo=3 hi=1.
//  4. DIV a=5 b=0 -> lo=0xFFFFFFFF hi=5;
//     DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
//  5. start and hi_we during busy -> ignored, result as if absent;
//     reset in RUN cycle 10 -> next cycle busy=0 hi=lo=0, no done.
//  6. WIDTH=8 instance, MULTU 0xFF*0xFF -> hi=0xFE lo=0x01;
//     busy high 9 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op/state encodings and magnitude helper for seq_muldiv
package muldiv_pkg;
  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam int ABS_W = 128;
  function automatic logic [ABS_W-1:0] abs_val(input logic [ABS_W-1:0] x);
    return x[ABS_W-1] ? -x : x;
  endfunction
endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: sign correction and divide-by-zero override of the raw magnitude result
module muldiv_signfix import muldiv_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] raw,
  input  logic [1:0]         op,
  input  logic               a_neg,
  input  logic               b_neg,
  input  logic               b_zero,
  input  logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);
  logic is_div;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem;
  always_comb begin
    is_div = op == OP_DIVU || op == OP_DIV;
    prod = (a_neg ^ b_neg) ? -raw : raw;
    quo = (a_neg ^ b_neg) ? -raw[WIDTH-1:0] : raw[WIDTH-1:0];
    rem = a_neg ? -raw[2*WIDTH-1:WIDTH] : raw[2*WIDTH-1:WIDTH];
    lo = !is_div ? prod[WIDTH-1:0] : b_zero ? '1 : quo;
    hi = !is_div ? prod[2*WIDTH-1:WIDTH] : b_zero ? a : rem;
  end
endmodule

// File: rtl/seq_muldiv.sv
// seq_muldiv: iterative radix-2 multiply/divide unit with architectural HI/LO registers
module seq_muldiv import muldiv_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  logic [1:0] state, op_q;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] mcand, a_q, a_mag, b_mag, fix_hi, fix_lo;
  logic [WIDTH:0] sum, part;
  logic a_neg, b_neg, b_zero, sgn, ge;
  always_comb begin
    sgn = op == OP_MULT || op == OP_DIV;
    a_mag = sgn ? WIDTH'(abs_val(ABS_W'(signed'(a)))) : a;
    b_mag = sgn ? WIDTH'(abs_val(ABS_W'(signed'(b)))) : b;
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? mcand : '0};
    part = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge = part >= {1'b0, mcand};
    acc_nxt = op_q[1]
      ? {ge ? WIDTH'(part - {1'b0, mcand}) : part[WIDTH-1:0], acc[WIDTH-2:0], ge}
      : {sum, acc[WIDTH-1:1]};
  end
  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .raw(acc),
    .op(op_q),
    .a_neg(a_neg),
    .b_neg(b_neg),
    .b_zero(b_zero),
    .a(a_q),
    .hi(fix_hi),
    .lo(fix_lo)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      hi <= '0;
      lo <= '0;
      cnt <= '0;
    end else begin
      done <= state == S_FIX;
      if (state == S_IDLE) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
        if (start) begin
          state <= S_RUN;
          busy <= 1'b1;
          cnt <= '0;
          op_q <= op;
          a_q <= a;
          mcand <= b_mag;
          acc <= {{WIDTH{1'b0}}, a_mag};
          a_neg <= sgn & a[WIDTH-1];
          b_neg <= sgn & b[WIDTH-1];
          b_zero <= b == '0;
        end
      end else if (state == S_RUN) begin
        acc <= acc_nxt;
        cnt <= cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) state <= S_FIX;
      end else begin
        hi <= fix_hi;
        lo <= fix_lo;
        busy <= 1'b0;
        state <= S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_seq_muldiv.sv
// tb_seq_muldiv: table, hand-written and random checks of seq_muldiv at WIDTH 32 and 8
module tb_seq_muldiv;
  import muldiv_pkg::*;
  logic clk = 1'b0;
  logic reset, start, hi_we, lo_we;
  logic [1:0] op;
  logic [31:0] a, b, wdata, hi, lo;
  logic busy, done, busy8, done8;
  logic [7:0] hi8, lo8;
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  seq_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  seq_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a[7:0]), .b(b[7:0]),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata[7:0]),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;
  vec_t vecs[6];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  function automatic logic [63:0] model(input int w, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint mask, ua, ub, sa, sb, q, r;
    logic [63:0] p;
    mask = (longint'(1) << w) - 1;
    ua = longint'(x) & mask;
    ub = longint'(y) & mask;
    sa = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
    sb = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
    if (o == OP_MULTU || o == OP_MULT) begin
      p = (o == OP_MULTU) ? ua * ub : sa * sb;
      q = longint'(p) & mask;
      r = longint'(p >> w) & mask;
    end else if (ub == 0) begin
      q = mask;
      r = ua;
    end else if (o == OP_DIVU) begin
      q = ua / ub;
      r = ua % ub;
    end else begin
      q = (sa / sb) & mask;
      r = (sa % sb) & mask;
    end
    return {r[31:0], q[31:0]};
  endfunction
  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     output logic [31:0] rh, output logic [31:0] rl,
                     output logic [7:0] rh8, output logic [7:0] rl8,
                     output int bc, output int dc, output int bc8, output int dc8);
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 2'($urandom_range(0, 3));
    {rh, rl, rh8, rl8} = '0;
    {bc, dc, bc8, dc8} = {32'd0, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 60; i++) begin
      bc += int'(busy);
      dc += int'(done);
      bc8 += int'(busy8);
      dc8 += int'(done8);
      if (done) {rh, rl} = {hi, lo};
      if (done8) {rh8, rl8} = {hi8, lo8};
      if (dc > 0 && !done && dc8 > 0 && !done8) break;
      @(negedge clk);
    end
  endtask
  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 60 && !done; i++) @(negedge clk);
    chk({name, "_done_seen"}, 64'(done), 64'd1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] rh, rl, x, y;
    logic [7:0] rh8, rl8;
    logic [63:0] e, e8;
    logic [1:0] o;
    int bc, dc, bc8, dc8, n_done, n_busy;
    vecs[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
    vecs[4] = '{OP_DIV,   32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
    vecs[5] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    reset = 1'b1;
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    op = OP_MULTU;
    a = '0;
    b = '0;
    wdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_hilo8", {48'd0, hi8, lo8}, 64'd0);
    reset = 1'b0;
    foreach (vecs[i]) begin
      run(vecs[i].op, vecs[i].a, vecs[i].b, rh, rl, rh8, rl8, bc, dc, bc8, dc8);
      e8 = model(8, vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("vec%0d_hi", i), 64'(rh), 64'(vecs[i].hi));
      chk($sformatf("vec%0d_lo", i), 64'(rl), 64'(vecs[i].lo));
      chk($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'd33);
      chk($sformatf("vec%0d_done_pulses", i), 64'(dc), 64'd1);
      chk($sformatf("vec%0d_w8_hilo", i), {48'd0, rh8, rl8}, {48'd0, e8[39:32], e8[7:0]});
      chk($sformatf("vec%0d_w8_busy_cycles", i), 64'(bc8), 64'd9);
      chk($sformatf("vec%0d_w8_done_pulses", i), 64'(dc8), 64'd1);
    end
    run(OP_MULTU, 32'h000000FF, 32'h000000FF, rh, rl, rh8, rl8, bc, dc, bc8, dc8);
    chk("w8_multu_ff_hi", 64'(rh8), 64'hFE);
    chk("w8_multu_ff_lo", 64'(rl8), 64'h01);
    chk("w8_multu_ff_busy", 64'(bc8), 64'd9);
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = '0;
        1: begin x = 32'h80000000; y = '1; end
        2: y = 32'($urandom_range(1, 15));
        3: begin x = 32'h00000080; y = 32'h000000FF; end
        default: ;
      endcase
      run(o, x, y, rh, rl, rh8, rl8, bc, dc, bc8, dc8);
      e = model(32, o, x, y);
      e8 = model(8, o, x, y);
      chk($sformatf("rnd%0d_op%0d_%h_%h", i, o, x, y), {rh, rl}, e);
      chk($sformatf("rnd%0d_w8_op%0d_%h_%h", i, o, x[7:0], y[7:0]), {48'd0, rh8, rl8}, {48'd0, e8[39:32], e8[7:0]});
      chk($sformatf("rnd%0d_busy_done", i), {32'(bc), 32'(dc)}, {32'd33, 32'd1});
    end
    @(negedge clk);
    hi_we = 1'b1;
    wdata = 32'hCAFE0001;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi_idle", 64'(hi), 64'hCAFE0001);
    lo_we = 1'b1;
    wdata = 32'hCAFE0002;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo_idle", 64'(lo), 64'hCAFE0002);
    chk("mtlo_keeps_hi", 64'(hi), 64'hCAFE0001);
    start = 1'b1;
    op = OP_MULTU;
    a = 32'd3;
    b = 32'd5;
    hi_we = 1'b1;
    wdata = 32'h5A5A5A5A;
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b0;
    chk("same_edge_hi_written", 64'(hi), 64'h5A5A5A5A);
    chk("same_edge_busy", 64'(busy), 64'd1);
    repeat (5) @(negedge clk);
    chk("run_lo_holds_old", 64'(lo), 64'hCAFE0002);
    wait_done("same_edge");
    chk("same_edge_result", {hi, lo}, 64'd15);
    @(negedge clk);
    start = 1'b1;
    op = OP_MULTU;
    a = 32'd6;
    b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    op = OP_DIV;
    a = 32'd100;
    b = 32'd3;
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    chk("busy_write_ignored", {hi, lo}, 64'd15);
    wait_done("busy_ignore");
    chk("busy_ignore_result", {hi, lo}, 64'd42);
    @(negedge clk);
    chk("start_not_queued", 64'(busy), 64'd0);
    start = 1'b1;
    op = OP_MULTU;
    a = 32'hFFFFFFFF;
    b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midop_reset_busy", 64'(busy), 64'd0);
    chk("midop_reset_done", 64'(done), 64'd0);
    chk("midop_reset_hilo", {hi, lo}, 64'd0);
    n_done = 0;
    n_busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_done += int'(done);
      n_busy += int'(busy);
    end
    chk("midop_reset_no_done", 64'(n_done), 64'd0);
    chk("midop_reset_stays_idle", 64'(n_busy), 64'd0);
    chk("midop_reset_hilo_after", {hi, lo}, 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
